// File: rtl/norm_multi_if.sv
// -----------------------------------------------------------------------------
// norm_multi_if
// Bundle of the norm_multi data ports.
//   Input side  : s_valid / s_ready per core, psum (NUM_CORE x COL x BW_PSUM).
//   Output side : m_valid / m_ready, psum_norm (NUM_CORE x W_OUT), m_idx,
//                 m_last, div_zero.
// Modports:
//   slave  - the normalizer (consumes vectors, produces normalized elements)
//   master - the environment (produces vectors, consumes normalized elements)
// -----------------------------------------------------------------------------
interface norm_multi_if #(
    parameter int BW_PSUM  = 16,
    parameter int COL      = 8,
    parameter int NUM_CORE = 4,
    parameter int W_OUT    = 16
);
    localparam int IDX_W = (COL > 1) ? $clog2(COL) : 1;

    logic [NUM_CORE-1:0]                        s_valid;
    logic [NUM_CORE-1:0]                        s_ready;
    logic [NUM_CORE-1:0][COL-1:0][BW_PSUM-1:0]  psum;

    logic                                       m_valid;
    logic                                       m_ready;
    logic [NUM_CORE-1:0][W_OUT-1:0]             psum_norm;
    logic [IDX_W-1:0]                           m_idx;
    logic                                       m_last;
    logic                                       div_zero;

    modport slave (
        input  s_valid, psum, m_ready,
        output s_ready, m_valid, psum_norm, m_idx, m_last, div_zero
    );

    modport master (
        output s_valid, psum, m_ready,
        input  s_ready, m_valid, psum_norm, m_idx, m_last, div_zero
    );
endinterface

// File: rtl/norm_multi.sv
// -----------------------------------------------------------------------------
// norm_multi
// Collects one signed COL-element vector from each of NUM_CORE cores (in any
// order), sums every element of the whole group, then streams out COL
// normalized elements: psum_norm[c] = (psum[c][idx] << FRAC_BITS) / sum,
// truncated toward zero and saturated to signed W_OUT. A zero group sum
// yields all-zero outputs with div_zero raised for the whole output phase.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-high
//   bus.slave  - s_valid/s_ready/psum collection side,
//                m_valid/m_ready/psum_norm/m_idx/m_last/div_zero output side
// -----------------------------------------------------------------------------
module norm_multi #(
    parameter int BW_PSUM   = 16,
    parameter int COL       = 8,
    parameter int NUM_CORE  = 4,
    parameter int FRAC_BITS = 8,
    parameter int W_OUT     = 16
) (
    input  logic         clk,
    input  logic         reset,
    norm_multi_if.slave  bus
);
    localparam int IDX_W = (COL > 1) ? $clog2(COL) : 1;
    localparam int ACC_W = BW_PSUM + $clog2(COL * NUM_CORE);
    localparam int NUM_W = BW_PSUM + FRAC_BITS;
    // One spare bit so the shifted numerator and the sum both fit signed.
    localparam int DIV_W = ((NUM_W > ACC_W) ? NUM_W : ACC_W) + 1;

    localparam logic signed [DIV_W-1:0] Q_MAX = DIV_W'((longint'(1) <<< (W_OUT - 1)) - 1);
    localparam logic signed [DIV_W-1:0] Q_MIN = ~Q_MAX;

    typedef enum logic [1:0] {
        IDLE,
        SUM,
        OUT
    } state_t;

    state_t                                     r_state;
    logic [NUM_CORE-1:0]                        r_captured;
    logic [NUM_CORE-1:0][COL-1:0][BW_PSUM-1:0]  r_buf;
    logic signed [ACC_W-1:0]                    r_acc;
    logic [IDX_W-1:0]                           r_col;
    logic [IDX_W-1:0]                           r_idx;
    logic                                       r_m_valid;
    logic                                       r_m_last;
    logic                                       r_div_zero;

    logic [NUM_CORE-1:0]                        w_cap;
    logic signed [ACC_W-1:0]                    w_col_sum;
    logic signed [ACC_W-1:0]                    w_acc_next;
    logic [NUM_CORE-1:0][W_OUT-1:0]             w_norm;

    // Signed divide truncating toward zero, then clamp to the W_OUT range.
    function automatic logic [W_OUT-1:0] norm_elem(
        input logic [BW_PSUM-1:0]     elem,
        input logic signed [ACC_W-1:0] den
    );
        logic signed [DIV_W-1:0] num;
        logic signed [DIV_W-1:0] dd;
        logic signed [DIV_W-1:0] quo;
        num = DIV_W'($signed(elem)) <<< FRAC_BITS;
        dd  = DIV_W'(den);
        if (den == '0)
            return '0;
        quo = num / dd;
        if (quo > Q_MAX)
            return Q_MAX[W_OUT-1:0];
        if (quo < Q_MIN)
            return Q_MIN[W_OUT-1:0];
        return quo[W_OUT-1:0];
    endfunction

    // Ready only for cores still missing while collecting.
    assign bus.s_ready = (r_state == IDLE) ? ~r_captured : '0;
    assign w_cap       = bus.s_valid & bus.s_ready;

    // Column sum of element r_col across every core.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it
        // unassigned and infers a latch.
        w_col_sum = '0;
        for (int c = 0; c < NUM_CORE; c++)
            w_col_sum = w_col_sum + ACC_W'($signed(r_buf[c][r_col]));
    end

    assign w_acc_next = r_acc + w_col_sum;

    always_comb begin
        w_norm = '0;
        if (r_state == OUT && !r_div_zero) begin
            for (int c = 0; c < NUM_CORE; c++)
                w_norm[c] = norm_elem(r_buf[c][r_idx], r_acc);
        end
    end

    // NOTE: the vector buffer has no reset; the captured flags decide
    // whether its contents are meaningful, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CORE; c++)
            if (w_cap[c])
                r_buf[c] <= bus.psum[c];
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_captured <= '0;
            r_acc      <= '0;
            r_col      <= '0;
            r_idx      <= '0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Leave one cycle after the final capture so the buffer
                    // is settled before the first column is summed.
                    if (&r_captured) begin
                        r_state <= SUM;
                        r_acc   <= '0;
                        r_col   <= '0;
                    end else begin
                        r_captured <= r_captured | w_cap;
                    end
                end

                SUM: begin
                    r_acc <= w_acc_next;
                    r_col <= r_col + IDX_W'(1);
                    if (r_col == IDX_W'(COL - 1)) begin
                        r_state    <= OUT;
                        r_idx      <= '0;
                        r_m_valid  <= 1'b1;
                        r_m_last   <= (COL == 1);
                        r_div_zero <= (w_acc_next == '0);
                    end
                end

                OUT: begin
                    if (bus.m_ready) begin
                        if (r_m_last) begin
                            r_state    <= IDLE;
                            r_captured <= '0;
                            r_idx      <= '0;
                            r_m_valid  <= 1'b0;
                            r_m_last   <= 1'b0;
                            r_div_zero <= 1'b0;
                        end else begin
                            r_idx    <= r_idx + IDX_W'(1);
                            r_m_last <= ((r_idx + IDX_W'(1)) == IDX_W'(COL - 1));
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.m_valid   = r_m_valid;
    assign bus.m_last    = r_m_last;
    assign bus.m_idx     = r_idx;
    assign bus.div_zero  = r_div_zero;
    assign bus.psum_norm = w_norm;

endmodule

// File: doc/norm_multi.md
NORM_MULTI -- requirements
Module: norm_multi

Interface
REQ-001 SHALL have parameter BW_PSUM, default 16, meaning width of each signed partial-sum element.
REQ-002 SHALL have parameter COL, default 8, meaning elements per input vector.
REQ-003 SHALL have parameter NUM_CORE, default 4, meaning number of independent input channels (cores).
REQ-004 SHALL have parameter FRAC_BITS, default 8, meaning left shift applied to each numerator before division.
REQ-005 SHALL have parameter W_OUT, default 16, meaning width of each signed normalized output.
REQ-006 SHALL have one clock, clk, input, 1 bit; all state updates on its rising edge.
REQ-007 SHALL have reset, input, 1 bit; reset is synchronous and active-high.
REQ-008 SHALL have s_valid, input, NUM_CORE bits; per-core input vector valid.
REQ-009 SHALL have s_ready, output, NUM_CORE bits; per-core input vector accept.
REQ-010 SHALL have psum, input, NUM_CORE x COL x BW_PSUM bits; signed per-core input vectors.
REQ-011 SHALL have m_valid, output, 1 bit; normalized element valid.
REQ-012 SHALL have m_ready, input, 1 bit; downstream accept.
REQ-013 SHALL have psum_norm, output, NUM_CORE x W_OUT bits; element idx of each core, normalized.
REQ-014 SHALL have m_idx, output, clog2(COL) bits; element index currently presented.
REQ-015 SHALL have m_last, output, 1 bit; high with m_valid when m_idx == COL-1.
REQ-016 SHALL have div_zero, output, 1 bit; high while presenting a group whose total sum is 0.

Function
REQ-017 SHALL implement states IDLE (collecting), SUM, OUT.
REQ-018 SHALL, in IDLE, drive s_ready[c]=1 for every core c not yet captured, and 0 for captured cores.
REQ-019 SHALL capture psum[c] into a per-core buffer on a cycle with s_valid[c] && s_ready[c]; cores capture independently, in any order, several in the same cycle.
REQ-020 SHALL ignore s_valid[c] on an already-captured core; the buffer is not overwritten.
REQ-021 SHALL move IDLE->SUM on the cycle after the last outstanding core is captured; all s_ready SHALL be 0 in SUM and OUT.
REQ-022 SHALL, in SUM, add the element-i column of all cores into a signed accumulator of width BW_PSUM+clog2(COL*NUM_CORE), one column per cycle, for exactly COL cycles, then move to OUT.
REQ-023 SHALL, in OUT, assert m_valid with m_idx starting at 0, and advance m_idx only on m_valid && m_ready; m_idx and psum_norm SHALL hold stable while m_ready is 0.
REQ-024 SHALL compute psum_norm[c] = (psum[c][m_idx] * 2^FRAC_BITS) / sum as signed division truncating toward zero.
REQ-025 SHALL saturate each quotient to the signed W_OUT range [-2^(W_OUT-1), 2^(W_OUT-1)-1].
REQ-026 SHALL, when sum == 0, output psum_norm = 0 for all elements and assert div_zero for the whole OUT phase.
REQ-027 SHALL move OUT->IDLE after the m_last element is accepted, with all s_ready high and captured flags clear on the following cycle.
REQ-028 SHALL give a latency of COL+1 cycles from the last capture edge to the first m_valid, absent reset.

Reset
REQ-029 SHALL, while reset is high at a clock edge, enter IDLE, clear all captured flags, accumulator and m_idx.
REQ-030 SHALL hold outputs after reset: s_ready all 1, m_valid 0, m_last 0, m_idx 0, div_zero 0, psum_norm 0.
REQ-031 SHALL abort any partial collection, SUM or OUT on reset with no output of the aborted group.

Verification (NUM_CORE=2, COL=8, FRAC_BITS=8, BW_PSUM=W_OUT=16)
REQ-032 SHALL pass: both cores psum[i]=i, m_ready=1 -> sum 56; element 7 outputs 32,32; element 1 outputs 4,4; first m_valid 9 cycles after capture.
REQ-033 SHALL pass: core0 all -1, core1 all 2 -> sum 8; every element outputs -32, 64; m_last high only at m_idx 7.
REQ-034 SHALL pass: core0 elem0=200, core1 elem0=-199, rest 0 -> sum 1; element 0 saturates to 32767, -32768; others 0.
REQ-035 SHALL pass: all inputs 0 -> div_zero=1 throughout OUT, all outputs 0.
REQ-036 SHALL pass: core1 captured 5 cycles before core0, core1 re-asserts s_valid with new data -> ignored; m_ready low 3 cycles at m_idx 3 -> idx and data held, no element lost or duplicated.
REQ-037 SHALL pass: reset asserted at m_idx 4 -> next cycle m_valid 0, s_ready 2'b11; a fresh group then normalizes correctly.
